// File: rtl/hub75_rx_if.sv
// ---------------------------------------------------------------------------
// hub75_rx_if : row delivery bus of the HUB75 receiver.
//   master : drives one captured row pair plus its address / length flag and
//            row_valid; samples row_ready.
//   slave  : consumer side.
// Ports (signals):
//   row_data0   NUM_COLS*3  upper row, column c at bits [3c+2:3c]
//   row_data1   NUM_COLS*3  lower row, same packing
//   row_addr    ADDR_BITS   row address sampled at latch
//   row_len_err 1           shift count of this row was not NUM_COLS
//   row_valid   1           row available
//   row_ready   1           consumer accepts
// ---------------------------------------------------------------------------
interface hub75_rx_if #(
  parameter int NUM_COLS  = 64,
  parameter int ADDR_BITS = 5
);
  logic [NUM_COLS*3-1:0] row_data0;
  logic [NUM_COLS*3-1:0] row_data1;
  logic [ADDR_BITS-1:0]  row_addr;
  logic                  row_len_err;
  logic                  row_valid;
  logic                  row_ready;

  modport master (
    output row_data0, row_data1, row_addr, row_len_err, row_valid,
    input  row_ready
  );

  modport slave (
    input  row_data0, row_data1, row_addr, row_len_err, row_valid,
    output row_ready
  );
endinterface

// File: rtl/hub75_rx.sv
// ---------------------------------------------------------------------------
// hub75_rx : HUB75 sink. Oversamples the panel pins on clk_in, rebuilds each
// shifted row pair into parallel column buffers and hands every latched row
// to a valid/ready consumer through a one-deep output buffer.
//
// Ports:
//   clk_in        system clock (HUB75 shift clock must be <= clk_in/4)
//   rst_in        synchronous, active-high reset
//   hub75_clk     panel shift clock
//   hub75_latch   row latch, active high
//   hub75_OE      output enable, active low
//   hub75_addr    row address
//   hub75_rgb0    upper-half pixel {r,g,b}
//   hub75_rgb1    lower-half pixel {r,g,b}
//   row_if        hub75_rx_if.master, captured row delivery (valid/ready)
//   overrun       sticky: a latched row was dropped, output buffer was full
//   oe_violation  sticky protocol error flag (optional check)
//
// Optional feature macro: HUB75_RX_OE_CHECK_EN
//   defined   : oe_violation flags a latch while the display is lit and a
//               shift clock edge while latch is high
//   undefined : oe_violation is tied low, no check logic
//
// Output FSM states:
//   state   | meaning
//   S_EMPTY | output buffer free, row_valid = 0
//   S_FULL  | output buffer holds a row, row_valid = 1
// ---------------------------------------------------------------------------
module hub75_rx #(
  parameter int NUM_COLS    = 64,
  parameter int ADDR_BITS   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 hub75_clk,
  input  logic                 hub75_latch,
  input  logic                 hub75_OE,
  input  logic [ADDR_BITS-1:0] hub75_addr,
  input  logic [2:0]           hub75_rgb0,
  input  logic [2:0]           hub75_rgb1,
  hub75_rx_if.master           row_if,
  output logic                 overrun,
  output logic                 oe_violation
);

  localparam int DW    = NUM_COLS * 3;
  localparam int PW    = 3 + ADDR_BITS + 6;
  localparam int CW    = $clog2(NUM_COLS + 2);
  localparam int CLK_B = PW - 1;
  localparam int LAT_B = PW - 2;
  localparam int OE_B  = PW - 3;
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_COLS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(NUM_COLS + 1);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  // ---------------- input synchronizers + history ----------------
  logic [PW-1:0] w_pins;
  logic [PW-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0] r_hist;
  logic [PW-1:0] w_synced;

  assign w_pins   = {hub75_clk, hub75_latch, hub75_OE, hub75_addr, hub75_rgb0, hub75_rgb1};
  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= w_synced;
    end
  end

  // Edge pulses are registered so they line up with r_hist, which then holds
  // the pin values from the same sample that produced the edge.
  logic r_clk_rise;
  logic r_lat_rise;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_clk_rise <= 1'b0;
      r_lat_rise <= 1'b0;
    end else begin
      r_clk_rise <= w_synced[CLK_B] & ~r_hist[CLK_B];
      r_lat_rise <= w_synced[LAT_B] & ~r_hist[LAT_B];
    end
  end

  // ---------------- shift registers and candidate row ----------------
  logic [DW-1:0]        r_sh0, r_sh1;
  logic [CW-1:0]        r_cnt;
  logic [DW-1:0]        w_sh0_nxt, w_sh1_nxt;
  logic [CW-1:0]        w_cnt_inc;
  logic                 r_cand_vld;
  logic [DW-1:0]        r_cand0, r_cand1;
  logic [ADDR_BITS-1:0] r_cand_addr;
  logic                 r_cand_err;

  // New pixel enters the top column; after NUM_COLS shifts the first pixel
  // has walked down to column 0.
  assign w_sh0_nxt = r_clk_rise ? {r_hist[5:3], r_sh0[DW-1:3]} : r_sh0;
  assign w_sh1_nxt = r_clk_rise ? {r_hist[2:0], r_sh1[DW-1:3]} : r_sh1;
  assign w_cnt_inc = (r_clk_rise && (r_cnt != CNT_SAT)) ? r_cnt + 1'b1 : r_cnt;

  // A shift coinciding with the latch edge lands in the candidate because
  // the candidate is taken from the post-shift values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sh0       <= '0;
      r_sh1       <= '0;
      r_cnt       <= '0;
      r_cand_vld  <= 1'b0;
      r_cand0     <= '0;
      r_cand1     <= '0;
      r_cand_addr <= '0;
      r_cand_err  <= 1'b0;
    end else begin
      r_sh0      <= w_sh0_nxt;
      r_sh1      <= w_sh1_nxt;
      r_cnt      <= r_lat_rise ? '0 : w_cnt_inc;
      r_cand_vld <= r_lat_rise;
      if (r_lat_rise) begin
        r_cand0     <= w_sh0_nxt;
        r_cand1     <= w_sh1_nxt;
        r_cand_addr <= r_hist[OE_B-1 -: ADDR_BITS];
        r_cand_err  <= (w_cnt_inc != CNT_FULL);
      end
    end
  end

  // ---------------- output FSM ----------------
  state_t r_state;
  logic   w_load;

  // The buffer takes a candidate when empty, or when the held row is being
  // accepted in the same cycle.
  assign w_load = r_cand_vld && ((r_state == S_EMPTY) || row_if.row_ready);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state            <= S_EMPTY;
      row_if.row_valid   <= 1'b0;
      row_if.row_data0   <= '0;
      row_if.row_data1   <= '0;
      row_if.row_addr    <= '0;
      row_if.row_len_err <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      if (w_load) begin
        row_if.row_data0   <= r_cand0;
        row_if.row_data1   <= r_cand1;
        row_if.row_addr    <= r_cand_addr;
        row_if.row_len_err <= r_cand_err;
      end
      case (r_state)
        S_EMPTY: begin
          if (r_cand_vld) begin
            row_if.row_valid <= 1'b1;
            r_state          <= S_FULL;
          end
        end
        S_FULL: begin
          if (row_if.row_ready) begin
            if (!r_cand_vld) begin
              row_if.row_valid <= 1'b0;
              r_state          <= S_EMPTY;
            end
          end else if (r_cand_vld) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          r_state          <= S_EMPTY;
          row_if.row_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- optional protocol check ----------------
`ifdef HUB75_RX_OE_CHECK_EN
  logic r_oe_viol;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_oe_viol <= 1'b0;
    end else if ((r_lat_rise && !r_hist[OE_B]) || (r_clk_rise && r_hist[LAT_B])) begin
      r_oe_viol <= 1'b1;
    end
  end

  assign oe_violation = r_oe_viol;
`else
  logic w_unused_oe;

  assign w_unused_oe  = r_hist[OE_B];
  assign oe_violation = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// ---------------------------------------------------------------------------
// tb_hub75_rx : scoreboard bench for hub75_rx. Every latch pushes the row the
// bench expects (from its own shift-register model) and the monitor pops and
// compares on each valid/ready transfer.
// ---------------------------------------------------------------------------
module tb_hub75_rx;
  localparam int NC = 64;
  localparam int AB = 5;
  localparam int DW = NC * 3;

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [AB-1:0] a;
    logic          e;
  } row_t;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          hub75_clk, hub75_latch, hub75_OE;
  logic [AB-1:0] hub75_addr;
  logic [2:0]    hub75_rgb0, hub75_rgb1;
  logic          overrun, oe_violation;

  hub75_rx_if #(.NUM_COLS(NC), .ADDR_BITS(AB)) rif ();

  hub75_rx #(.NUM_COLS(NC), .ADDR_BITS(AB), .SYNC_STAGES(2)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .hub75_clk    (hub75_clk),
    .hub75_latch  (hub75_latch),
    .hub75_OE     (hub75_OE),
    .hub75_addr   (hub75_addr),
    .hub75_rgb0   (hub75_rgb0),
    .hub75_rgb1   (hub75_rgb1),
    .row_if       (rif),
    .overrun      (overrun),
    .oe_violation (oe_violation)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;
  row_t sb[$];

  logic [DW-1:0] m_sh0 = '0;
  logic [DW-1:0] m_sh1 = '0;
  int            m_cnt = 0;

  logic [2:0]    cap_c10_0, cap_c10_1, cap_c0;
  logic [AB-1:0] cap_addr;
  logic          cap_err;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && rif.row_valid && rif.row_ready) begin
      row_t r;
      n_deliv++;
      if (sb.size() == 0) begin
        chk("sb_nonempty", DW'(sb.size()), DW'(1));
      end else begin
        r = sb.pop_front();
        chk("row_data0", rif.row_data0, r.d0);
        chk("row_data1", rif.row_data1, r.d1);
        chk("row_addr", DW'(rif.row_addr), DW'(r.a));
        chk("row_len_err", DW'(rif.row_len_err), DW'(r.e));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cycles(3);
    rst_in = 1'b0;
    m_sh0  = '0;
    m_sh1  = '0;
    m_cnt  = 0;
  endtask

  task automatic shift_px(input logic [2:0] p0, input logic [2:0] p1);
    hub75_rgb0 = p0;
    hub75_rgb1 = p1;
    hub75_clk  = 1'b0;
    cycles(2);
    hub75_clk  = 1'b1;
    cycles(2);
    m_sh0 = {p0, m_sh0[DW-1:3]};
    m_sh1 = {p1, m_sh1[DW-1:3]};
    if (m_cnt < NC + 1) m_cnt++;
  endtask

  task automatic shift_row(input int n);
    for (int i = 0; i < n; i++) shift_px(3'(i), ~3'(i));
  endtask

  // Drives latch high just after an edge; the next edge (N) samples it.
  // With meas set, measures edges from N to row_valid and captures the row.
  task automatic pulse_latch(input bit meas, input bit drop);
    row_t r;
    int   n;
    r.d0 = m_sh0;
    r.d1 = m_sh1;
    r.a  = hub75_addr;
    r.e  = (m_cnt != NC);
    if (!drop) sb.push_back(r);
    m_cnt = 0;
    hub75_latch = 1'b1;
    cycles(2);
    hub75_latch = 1'b0;
    if (meas) begin
      n = 0;
      for (int k = 2; k <= 8 && n == 0; k++) begin
        cycles(1);
        if (rif.row_valid) begin
          n         = k;
          cap_c10_0 = rif.row_data0[32:30];
          cap_c10_1 = rif.row_data1[32:30];
          cap_c0    = rif.row_data0[2:0];
          cap_addr  = rif.row_addr;
          cap_err   = rif.row_len_err;
        end
      end
      chk("latency", DW'(n), DW'(4));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] hold_d0;
    int            cnt, d_start;
    logic          exp_oe;

    rst_in = 1'b1;
    hub75_clk = 1'b0; hub75_latch = 1'b0; hub75_OE = 1'b1;
    hub75_addr = '0; hub75_rgb0 = '0; hub75_rgb1 = '0;
    rif.row_ready = 1'b1;
    #1;
    do_reset();

    // reset state and idle
    chk("rst_valid", DW'(rif.row_valid), DW'(0));
    chk("rst_data0", rif.row_data0, DW'(0));
    chk("rst_data1", rif.row_data1, DW'(0));
    chk("rst_addr", DW'(rif.row_addr), DW'(0));
    chk("rst_len_err", DW'(rif.row_len_err), DW'(0));
    chk("rst_overrun", DW'(overrun), DW'(0));
    chk("rst_oe_viol", DW'(oe_violation), DW'(0));
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (rif.row_valid) cnt++;
    end
    chk("idle_valid_cycles", DW'(cnt), DW'(0));

    // full row, addr 5
    hub75_addr = 5'd5;
    shift_row(NC);
    d_start = n_deliv;
    pulse_latch(1'b1, 1'b0);
    chk("row5_col10_rgb0", DW'(cap_c10_0), DW'(3'b010));
    chk("row5_col10_rgb1", DW'(cap_c10_1), DW'(3'b101));
    chk("row5_addr", DW'(cap_addr), DW'(5));
    chk("row5_len_err", DW'(cap_err), DW'(0));
    cycles(10);
    chk("row5_pulses", DW'(n_deliv - d_start), DW'(1));

    // short and long rows
    hub75_addr = 5'd6;
    shift_row(NC - 1);
    pulse_latch(1'b1, 1'b0);
    chk("short_len_err", DW'(cap_err), DW'(1));
    cycles(10);
    hub75_addr = 5'd7;
    shift_row(NC + 2);
    pulse_latch(1'b1, 1'b0);
    chk("long_len_err", DW'(cap_err), DW'(1));
    chk("long_col0", DW'(cap_c0), DW'(2));
    cycles(10);
    chk("sb_drained_a", DW'(sb.size()), DW'(0));

    // overrun: consumer stalled across two rows
    rif.row_ready = 1'b0;
    hub75_addr = 5'd1;
    shift_row(NC);
    hold_d0 = m_sh0;
    pulse_latch(1'b0, 1'b0);
    hub75_addr = 5'd2;
    for (int i = 0; i < NC; i++) shift_px(3'(i + 3), 3'(i + 5));
    pulse_latch(1'b0, 1'b1);
    cycles(10);
    chk("stall_valid", DW'(rif.row_valid), DW'(1));
    chk("stall_addr", DW'(rif.row_addr), DW'(1));
    chk("stall_data0", rif.row_data0, hold_d0);
    chk("overrun_set", DW'(overrun), DW'(1));
    rif.row_ready = 1'b1;
    cycles(10);
    chk("stall_released", DW'(rif.row_valid), DW'(0));
    chk("sb_drained_b", DW'(sb.size()), DW'(0));

    // back-to-back latches, 70 cycles apart, addr 0..31
    do_reset();
    chk("overrun_cleared", DW'(overrun), DW'(0));
    d_start = n_deliv;
    hub75_addr = 5'd0;
    shift_row(NC);
    for (int a = 0; a < 32; a++) begin
      hub75_addr = 5'(a);
      pulse_latch(1'b0, 1'b0);
      cycles(68);
    end
    cycles(10);
    chk("b2b_rows", DW'(n_deliv - d_start), DW'(32));
    chk("b2b_overrun", DW'(overrun), DW'(0));
    chk("sb_drained_c", DW'(sb.size()), DW'(0));

    // latch while display lit
`ifdef HUB75_RX_OE_CHECK_EN
    exp_oe = 1'b1;
`else
    exp_oe = 1'b0;
`endif
    hub75_addr = 5'd9;
    hub75_OE = 1'b0;
    pulse_latch(1'b0, 1'b0);
    hub75_OE = 1'b1;
    cycles(10);
    chk("oe_viol_set", DW'(oe_violation), DW'(exp_oe));
    cycles(30);
    chk("oe_viol_sticky", DW'(oe_violation), DW'(exp_oe));
    chk("sb_drained_d", DW'(sb.size()), DW'(0));
    do_reset();
    chk("oe_viol_reset", DW'(oe_violation), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
